// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared fetch-stage types and constants
package rv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc       = 32'h0;
        b.pc_plus4 = 32'h0;
        b.instr    = nop;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - control, imem and IF/ID signal bundle
interface instruction_fetch_unit_if;
    logic        STALL;
    logic        FLUSH;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_INSTRUCTION;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC_PLUS4;
    logic [31:0] IF_ID_INSTRUCTION;
    logic        IF_ID_VALID;
    logic        HALTED;
    logic        MISALIGNED;
    logic [31:0] FETCH_COUNT;

    modport master (
        input  STALL, FLUSH, BRANCH_TAKEN, BRANCH_TARGET, IMEM_INSTRUCTION,
        output IMEM_ADDR, IF_ID_PC, IF_ID_PC_PLUS4, IF_ID_INSTRUCTION,
               IF_ID_VALID, HALTED, MISALIGNED, FETCH_COUNT
    );

    modport slave (
        output STALL, FLUSH, BRANCH_TAKEN, BRANCH_TARGET, IMEM_INSTRUCTION,
        input  IMEM_ADDR, IF_ID_PC, IF_ID_PC_PLUS4, IF_ID_INSTRUCTION,
               IF_ID_VALID, HALTED, MISALIGNED, FETCH_COUNT
    );
endinterface

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with hold and bubble controls
module if_id_register
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = rv_fetch_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);
    if_id_t q_d;
    if_id_t q_q;

    // Bubble wins over hold: a redirect kills the stalled instruction.
    always_comb begin
        q_d = q_q;
        if (bubble) begin
            q_d = if_id_bubble(BUBBLE_INSTR);
        end else if (!hold) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= if_id_bubble(BUBBLE_INSTR);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC, redirect, halt-on-zero FSM
module instruction_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = rv_fetch_pkg::NOP_INSTR,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    instruction_fetch_unit_if.master  bus
);
    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  fetch_count_d, fetch_count_q;
    logic         halted_d, halted_q;
    logic         misaligned_d, misaligned_q;
    logic         ifid_hold, ifid_bubble;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_pc;
    if_id_t       ifid_d, ifid_q;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = {bus.BRANCH_TARGET[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        misaligned_d  = 1'b0;
        ifid_hold     = 1'b0;
        ifid_bubble   = 1'b0;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.instr    = bus.IMEM_INSTRUCTION;
        ifid_d.valid    = 1'b1;
        case (state_q)
            BOOT: begin
                ifid_bubble = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (bus.BRANCH_TAKEN) begin
                    pc_d         = redirect_pc;
                    ifid_bubble  = 1'b1;
                    misaligned_d = |bus.BRANCH_TARGET[1:0];
                end else if (bus.FLUSH) begin
                    pc_d        = pc_plus4;
                    ifid_bubble = 1'b1;
                end else if (bus.STALL) begin
                    ifid_hold = 1'b1;
                end else if (HALT_ON_ZERO && bus.IMEM_INSTRUCTION == 32'h0) begin
                    // The zero word marks unmapped memory; park on its address.
                    ifid_bubble = 1'b1;
                    state_d     = HALT;
                end else begin
                    pc_d          = pc_plus4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            HALT: begin
                ifid_bubble = 1'b1;
                if (bus.BRANCH_TAKEN) begin
                    pc_d         = redirect_pc;
                    misaligned_d = |bus.BRANCH_TARGET[1:0];
                    state_d      = RUN;
                end
            end
            default: begin
                ifid_bubble = 1'b1;
                state_d     = BOOT;
            end
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'h0;
            halted_q      <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
            misaligned_q  <= misaligned_d;
        end
    end

    if_id_register #(.BUBBLE_INSTR(NOP_INSTR)) u_if_id (
        .clk    (CLK),
        .rst    (RESET),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign bus.IMEM_ADDR         = {pc_q[31:2], 2'b00};
    assign bus.IF_ID_PC          = ifid_q.pc;
    assign bus.IF_ID_PC_PLUS4    = ifid_q.pc_plus4;
    assign bus.IF_ID_INSTRUCTION = ifid_q.instr;
    assign bus.IF_ID_VALID       = ifid_q.valid;
    assign bus.HALTED            = halted_q;
    assign bus.MISALIGNED        = misaligned_q;
    assign bus.FETCH_COUNT       = fetch_count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [64];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.IMEM_INSTRUCTION = mem[bus.IMEM_ADDR[7:2]];

    // Reference model: mode 0=boot, 1=run, 2=halt
    int          m_mode = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ifpc = 32'h0;
    logic [31:0] m_ifpc4 = 32'h0;
    logic [31:0] m_ifinstr = NOP;
    logic        m_ifvalid = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_cnt = 32'h0;

    task automatic m_bubble();
        m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ifinstr = NOP; m_ifvalid = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pc = 32'h0; m_bubble();
            m_halted = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else begin
            logic [31:0] w;
            w = mem[m_pc[7:2]];
            m_mis = 1'b0;
            if (m_mode == 0) begin
                m_bubble(); m_mode = 1;
            end else if (bus.BRANCH_TAKEN) begin
                m_pc = bus.BRANCH_TARGET & 32'hFFFF_FFFC;
                m_mis = (bus.BRANCH_TARGET % 4) != 0;
                m_bubble(); m_mode = 1;
            end else if (m_mode == 2) begin
                m_bubble();
            end else if (bus.FLUSH) begin
                m_pc = m_pc + 4; m_bubble();
            end else if (bus.STALL) begin
                // everything holds
            end else if (w == 32'h0) begin
                m_bubble(); m_mode = 2;
            end else begin
                m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_ifinstr = w; m_ifvalid = 1'b1;
                m_pc = m_pc + 4; m_cnt = m_cnt + 1;
            end
            m_halted = (m_mode == 2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("imem_addr", bus.IMEM_ADDR, m_pc);
            check("if_id_pc", bus.IF_ID_PC, m_ifpc);
            check("if_id_pc4", bus.IF_ID_PC_PLUS4, m_ifpc4);
            check("if_id_instr", bus.IF_ID_INSTRUCTION, m_ifinstr);
            check("if_id_valid", 32'(bus.IF_ID_VALID), 32'(m_ifvalid));
            check("halted", 32'(bus.HALTED), 32'(m_halted));
            check("misaligned", 32'(bus.MISALIGNED), 32'(m_mis));
            check("fetch_count", bus.FETCH_COUNT, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic s, input logic f, input logic b, input logic [31:0] t);
        bus.STALL = s; bus.FLUSH = f; bus.BRANCH_TAKEN = b; bus.BRANCH_TARGET = t;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (i << 7);
        mem[0] = 32'h00E0_0413;
        mem[1] = 32'h0000_0013;
        mem[5] = 32'h0000_0000;
        ctrl(0, 0, 0, 32'h0);
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 32'(bus.IF_ID_VALID), 32'h0);
        check("rst_addr", bus.IMEM_ADDR, 32'h0);
        check("rst_instr", bus.IF_ID_INSTRUCTION, NOP);
        check("rst_halted", 32'(bus.HALTED), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        tick();                                   // BOOT
        check("boot_valid", 32'(bus.IF_ID_VALID), 32'h0);
        tick();
        check("first_pc", bus.IF_ID_PC, 32'h0);
        check("first_instr", bus.IF_ID_INSTRUCTION, 32'h00E0_0413);
        check("first_valid", 32'(bus.IF_ID_VALID), 32'h1);
        check("first_addr", bus.IMEM_ADDR, 32'h4);
        tick();
        check("count_two", bus.FETCH_COUNT, 32'h2);
        check("addr_8", bus.IMEM_ADDR, 32'h8);

        ctrl(1, 0, 0, 32'h0);
        repeat (3) tick();
        check("stall_addr", bus.IMEM_ADDR, 32'h8);
        check("stall_ifpc", bus.IF_ID_PC, 32'h4);
        check("stall_count", bus.FETCH_COUNT, 32'h2);
        ctrl(0, 0, 0, 32'h0);
        tick();
        check("unstall_addr", bus.IMEM_ADDR, 32'hC);

        ctrl(1, 0, 1, 32'h40);
        tick();
        check("br_addr", bus.IMEM_ADDR, 32'h40);
        check("br_valid", 32'(bus.IF_ID_VALID), 32'h0);
        check("br_mis0", 32'(bus.MISALIGNED), 32'h0);
        ctrl(0, 0, 1, 32'h42);
        tick();
        check("mis_addr", bus.IMEM_ADDR, 32'h40);
        check("mis_pulse", 32'(bus.MISALIGNED), 32'h1);
        ctrl(0, 0, 0, 32'h0);
        tick();
        check("mis_clear", 32'(bus.MISALIGNED), 32'h0);
        check("br_fetch_pc", bus.IF_ID_PC, 32'h40);

        ctrl(0, 1, 0, 32'h0);
        tick();
        check("flush_valid", 32'(bus.IF_ID_VALID), 32'h0);
        check("flush_addr", bus.IMEM_ADDR, 32'h48);
        check("flush_count", bus.FETCH_COUNT, 32'h4);

        ctrl(0, 0, 1, 32'h10);
        tick();
        ctrl(1, 0, 0, 32'h0);
        tick();
        ctrl(0, 0, 0, 32'h0);
        tick();
        check("pre_halt_addr", bus.IMEM_ADDR, 32'h14);
        ctrl(1, 0, 0, 32'h0);
        tick();
        check("stall_no_halt", 32'(bus.HALTED), 32'h0);
        ctrl(0, 0, 0, 32'h0);
        tick();
        check("halted", 32'(bus.HALTED), 32'h1);
        check("halt_addr", bus.IMEM_ADDR, 32'h14);
        check("halt_valid", 32'(bus.IF_ID_VALID), 32'h0);
        ctrl(0, 1, 0, 32'h0);
        tick();
        ctrl(0, 0, 0, 32'h0);
        tick();
        check("halt_hold_addr", bus.IMEM_ADDR, 32'h14);
        check("halt_count", bus.FETCH_COUNT, 32'h5);
        ctrl(0, 0, 1, 32'h0);
        tick();
        check("resume_halted", 32'(bus.HALTED), 32'h0);
        check("resume_addr", bus.IMEM_ADDR, 32'h0);
        ctrl(0, 0, 0, 32'h0);
        tick();
        check("resume_valid", 32'(bus.IF_ID_VALID), 32'h1);
        check("resume_count", bus.FETCH_COUNT, 32'h6);
        repeat (3) tick();
        check("pre_rst_addr", bus.IMEM_ADDR, 32'h10);

        #2 rst = 1'b1;
        #1;
        check("async_addr", bus.IMEM_ADDR, 32'h0);
        check("async_valid", 32'(bus.IF_ID_VALID), 32'h0);
        check("async_count", bus.FETCH_COUNT, 32'h0);
        check("async_instr", bus.IF_ID_INSTRUCTION, NOP);
        check("async_ifpc", bus.IF_ID_PC, 32'h0);
        #3 rst = 1'b0;
        tick();
        check("reboot_valid", 32'(bus.IF_ID_VALID), 32'h0);
        check("reboot_addr", bus.IMEM_ADDR, 32'h0);
        tick();
        check("reboot_fetch", bus.IF_ID_INSTRUCTION, 32'h00E0_0413);
        check("reboot_count", bus.FETCH_COUNT, 32'h1);

        force dut.pc_q = 32'hFFFF_FFFC;
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        m_pc = 32'hFFFF_FFFC;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.pc_q;
        release dut.fetch_count_q;
        tick();
        check("wrap_addr", bus.IMEM_ADDR, 32'h0);
        check("wrap_count", bus.FETCH_COUNT, 32'h0);
        check("wrap_ifpc", bus.IF_ID_PC, 32'hFFFF_FFFC);
        check("wrap_ifpc4", bus.IF_ID_PC_PLUS4, 32'h0);
        check("wrap_instr", bus.IF_ID_INSTRUCTION, 32'h0000_1F93);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF-stage initiator that drives the instruction memory's combinational read port (address in, 32-bit instruction out, same cycle). Holds the PC and handles stall, flush and branch/jump redirect. Registers fetched words into the IF/ID pipeline register with a valid bit. Enters a HALT state when memory returns the all-zero word, which is the memory's value for unmapped or illegal locations.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned.
NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0; inserted into IF/ID on bubbles.
HALT_ON_ZERO, 1, 1 = fetched 32'h0 halts fetch; 0 = treated as a normal word.

Ports:
CLK  in  1  clock, rising-edge.
RESET  in  1  asynchronous, active-high reset.
STALL  in  1  hold PC and IF/ID (load-use hazard from ID).
FLUSH  in  1  squash IF/ID contents; PC continues.
BRANCH_TAKEN  in  1  redirect request from EX.
BRANCH_TARGET  in  32  redirect address.
IMEM_ADDR  out  32  address to instruction memory; equals PC, combinational.
IMEM_INSTRUCTION  in  32  instruction word returned same cycle.
IF_ID_PC  out  32  PC of the registered instruction.
IF_ID_PC_PLUS4  out  32  IF_ID_PC + 4.
IF_ID_INSTRUCTION  out  32  registered instruction.
IF_ID_VALID  out  1  IF/ID holds a real instruction.
HALTED  out  1  fetch is in the HALT state.
MISALIGNED  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.
FETCH_COUNT  out  32  count of valid instructions delivered to IF/ID; wraps.

Behaviour:
- Async reset. All outputs take their reset values immediately on RESET=1:
  - PC=RESET_PC
  - IF_ID_PC=0, IF_ID_PC_PLUS4=0
  - IF_ID_INSTRUCTION=NOP_INSTR, IF_ID_VALID=0
  - HALTED=0, MISALIGNED=0, FETCH_COUNT=0
  - state=BOOT
- Reset mid-operation discards all in-flight state with no partial update.
- IMEM_ADDR = {PC[31:2],2'b00} at all times. The memory decodes ADDR[7:2]; this block does not truncate the address.
- FSM states:
  - BOOT: one cycle, IF/ID loads a bubble, PC holds; always goes to RUN.
  - RUN: normal fetch.
  - HALT: PC frozen, IF/ID bubbles every cycle.
- Priority each edge in RUN: BRANCH_TAKEN > FLUSH > STALL > normal.
- Normal (RUN, no control): PC<=PC+4. IF/ID <= {PC, PC+4, IMEM_INSTRUCTION, valid=1}. FETCH_COUNT++.
- STALL only: PC and IF/ID hold; FETCH_COUNT holds.
- BRANCH_TAKEN (any state except BOOT):
  - PC<={BRANCH_TARGET[31:2],2'b00}.
  - IF/ID<=bubble (NOP_INSTR, valid=0, PC fields 0).
  - MISALIGNED=1 for that cycle if BRANCH_TARGET[1:0]!=0.
  - From HALT, a redirect returns the FSM to RUN.
  - Overrides a simultaneous STALL; the stalled ID instruction is younger than the branch and dies.
- FLUSH without BRANCH_TAKEN: PC<=PC+4; IF/ID<=bubble; no count.
- Halt detect (HALT_ON_ZERO=1, RUN, normal advance, IMEM_INSTRUCTION==0):
  - The zero word is not delivered; IF/ID<=bubble.
  - PC holds at the zero-word address.
  - Next state HALT; HALTED=1 from the following cycle.
  - STALL in the same cycle suppresses detection until the stall ends.
- FETCH_COUNT increments only when valid=1 is written. It wraps 32'hFFFF_FFFF -> 0.
- PC arithmetic is modulo 2^32: PC=32'hFFFF_FFFC advances to 0.
- Latency: a word addressed in cycle n appears on IF_ID_* after edge n+1. Redirect costs one bubble.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - NOP_INSTR constant and the fetch-state enum (BOOT, RUN, HALT).
  - IF/ID bundle typedef {pc, pc_plus4, instr, valid}, reused by the decoder.
- One natural sub-module, if_id_register: the pipeline register with hold/bubble controls. PC logic and the FSM stay in the top module.

Test Plan:
- Reset release, memory words 0x00E00413,0x00000013 at 0,4 -> cycle after BOOT: IF_ID_PC=0, INSTR=0x00E00413, VALID=1; next cycle PC=4; FETCH_COUNT=2 after two deliveries.
- STALL held 3 cycles at PC=8 -> IMEM_ADDR stays 8, IF_ID unchanged, FETCH_COUNT unchanged; releases to PC=12.
- BRANCH_TAKEN with target 0x40 while STALL=1 -> next edge PC=0x40, IF_ID_VALID=0, MISALIGNED=0; target 0x42 -> PC=0x40, MISALIGNED pulses 1 cycle.
- Memory returns 0 at address 0x14 -> IF_ID bubble, HALTED=1, IMEM_ADDR stays 0x14; redirect to 0 -> HALTED=0, fetch resumes at 0.
- RESET asserted asynchronously mid-cycle during RUN at PC=0x10 -> outputs hit reset values before the next edge; fetch restarts via BOOT at RESET_PC.
- Preload PC=0xFFFFFFFC and FETCH_COUNT=0xFFFFFFFF (via force) -> next edge PC=0, FETCH_COUNT=0.
